mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller for the 16-bit pipelined processor. It consumes the execute stage's results (`ALU_Out` as address, `MemWriteData` as store data), runs a request/acknowledge transaction against a variable-latency data memory, and stalls the pipeline until the access completes. It returns `Memory_read_data`, which feeds writeback and the execute-stage load forwarding path.

## Interface
**Parameters**
- TIMEOUT, default 15: maximum number of REQ cycles allowed without `mem_ack` before the access is aborted. Range is 1 to 255.

**Ports**
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- MemRead_cntrl  in  1  the instruction in this stage is a load.
- MemWrite_cntrl  in  1  the instruction in this stage is a store.
- ALU_Out  in  16  byte address from the execute stage.
- MemWriteData  in  16  store data from the execute stage.
- Memory_read_data  out  16  registered load result.
- Stall  out  1  holds all upstream pipeline registers this cycle.
- Err  out  1  sticky access error.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1 means write, 0 means read; valid while `mem_req` is high.
- mem_addr  out  16  registered address.
- mem_wdata  out  16  registered store data.
- mem_ack  in  1  memory completion; read data is valid in the same cycle.
- mem_rdata  in  16  read data.

## Operation
- An access is `acc = MemRead_cntrl | MemWrite_cntrl`. A bad access is any of:
  - `ALU_Out[0]` is 1 (misaligned word address), or
  - `MemRead_cntrl` and `MemWrite_cntrl` are both high.
- **IDLE**
  - `acc=0`: `Stall=0`, no transaction, and `Memory_read_data` holds its value.
  - `acc=1` and good: latch `ALU_Out`, `MemWriteData` and `MemWrite_cntrl` into `mem_addr`, `mem_wdata` and `mem_we`. Clear the wait counter and go to REQ. `Stall=1`.
  - `acc=1` and bad: set `Err`, issue no request, go to DONE. `Stall=1`.
- **REQ**
  - `mem_req=1` and `Stall=1`.
  - `mem_addr`, `mem_wdata` and `mem_we` stay stable for the whole state.
  - `mem_ack=1`:
    - Read: capture `mem_rdata` into `Memory_read_data`.
    - Write: leave `Memory_read_data` unchanged.
    - Go to DONE.
  - `mem_ack=0`: increment the wait counter. When it reaches TIMEOUT, set `Err`, load `Memory_read_data` with 16'h0000, and go to DONE.
- **DONE**
  - `Stall=0` and `mem_req=0`, so upstream advances at this edge.
  - The same instruction is still on the inputs. It is not re-issued.
  - Unconditional next state: IDLE.
- `mem_ack` is ignored outside REQ.
- `Err` is set only as above and is cleared only by `rst`.
- The wait counter is 8 bits.

## Timing
- **Reset values:** state IDLE. `Memory_read_data`, `mem_addr` and `mem_wdata` are 16'h0000. `mem_req`, `mem_we`, `Err` and the counter are 0.
- **Outputs:** `mem_req` is a decode of registered state. `Stall` is combinational from the state and `acc`.
- **Load latency with ack after k REQ cycles (k ≥ 1):**
  - `Stall` is high for 1+k cycles.
  - The DONE cycle follows.
  - `Memory_read_data` is valid from the DONE cycle onward.
- **Minimum per access:** 3 cycles (IDLE, REQ, DONE).
- **Timeout:** REQ lasts exactly TIMEOUT cycles, then DONE follows.
- **Reset in any state:** IDLE at the next edge, and `mem_req` drops in that cycle.
- **Back-to-back accesses:** one DONE cycle always separates two consecutive accesses.

## Structure
- A shared include/package holds:
  - state encodings `ST_IDLE=2'b00`, `ST_REQ=2'b01`, `ST_DONE=2'b10`;
  - the error-response constant 16'h0000.
- One sub-module, `wait_counter`: an 8-bit counter with synchronous clear and enable, and a terminal flag compared against TIMEOUT.
- Everything else lives in the top-level FSM.

## Test plan
- **Aligned load.** `MemRead=1`, `ALU_Out=16'h0040`, `mem_ack` after 2 REQ cycles with `mem_rdata=16'hBEEF`.
  - `Stall` is high 3 cycles; `mem_addr=16'h0040` and `mem_we=0` during REQ.
  - `Memory_read_data=16'hBEEF` in DONE; `Err=0`.
- **Store, same-cycle ack.** `MemWrite=1`, `ALU_Out=16'h0010`, `MemWriteData=16'h1234`, ack in the first REQ cycle.
  - `mem_we=1`, `mem_wdata=16'h1234`.
  - `Stall` is high 2 cycles; `Memory_read_data` unchanged.
- **Misaligned access.** `ALU_Out=16'h0003`, load.
  - `mem_req` is never asserted; `Stall` is high 1 cycle.
  - `Err=1` and stays 1 through later good accesses until `rst`.
- **Timeout with TIMEOUT=4.** `mem_ack` held 0.
  - `mem_req` is high exactly 4 cycles.
  - Then `Err=1`, `Memory_read_data=16'h0000`, DONE, IDLE.
- **Reset during REQ.** Assert `rst` in the 2nd REQ cycle.
  - Next cycle: `mem_req=0`, `Stall=0`, all outputs at reset values.
  - A late `mem_ack` is ignored.
- **Non-memory instructions and back-to-back loads.**
  - With `acc=0`, `Stall` stays 0 and `Memory_read_data` holds.
  - Two consecutive loads are separated by exactly one DONE cycle.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the memory-stage access controller:
//   FSM state encodings, the data value returned on an aborted access,
//   the wait counter width and the bad-access decode.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Load result substituted when an access times out.
  localparam logic [15:0] ERR_RDATA = 16'h0000;

  localparam int unsigned CNT_W = 8;

  // An access is refused when the word address is odd or when the
  // instruction claims to be both a load and a store.
  function automatic logic is_bad_access(input logic rd,
                                         input logic wr,
                                         input logic addr_lsb);
    return addr_lsb | (rd & wr);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// wait_counter
//   8-bit up-counter of REQ cycles spent without an acknowledge.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clr       - synchronous clear (new access accepted)
//     en        - count one more unacknowledged REQ cycle
//     terminal  - high when the cycle being counted now is the TIMEOUT-th
module wait_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam logic [CNT_W:0] TC = (CNT_W + 1)'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Compare the value the counter is about to take, so the abort fires in
  // the same cycle the count reaches TIMEOUT; REQ then lasts exactly
  // TIMEOUT cycles.
  assign terminal = (({1'b0, count} + 9'd1) == TC);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access controller. Takes the execute-stage address and
//   store data, runs one request/acknowledge transaction against a
//   variable-latency data memory and stalls the pipeline until it ends.
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     MemRead_cntrl     - instruction in this stage is a load
//     MemWrite_cntrl    - instruction in this stage is a store
//     ALU_Out[15:0]     - byte address from execute
//     MemWriteData[15:0]- store data from execute
//     Memory_read_data  - registered load result
//     Stall             - hold upstream pipeline registers this cycle
//     Err               - sticky access error (misaligned, conflict, timeout)
//     mem_req/mem_we    - memory request, write strobe (valid with req)
//     mem_addr/mem_wdata- registered address and store data
//     mem_ack/mem_rdata - memory completion, read data valid with ack
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no access in flight; accept a new one when acc is high
//   ST_REQ  | request held to memory, waiting for mem_ack or timeout
//   ST_DONE | access finished; release stall for one cycle, no re-issue
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_cntrl,
  input  logic        MemWrite_cntrl,
  input  logic [15:0] ALU_Out,
  input  logic [15:0] MemWriteData,
  output logic [15:0] Memory_read_data,
  output logic        Stall,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  state_t state;
  state_t state_nx;

  logic acc;
  logic bad;
  logic accept;
  logic refuse;
  logic ack_take;
  logic timeout;
  logic cnt_clr;
  logic cnt_en;
  logic wait_last;

  assign acc = MemRead_cntrl | MemWrite_cntrl;
  assign bad = acc & is_bad_access(MemRead_cntrl, MemWrite_cntrl, ALU_Out[0]);

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .terminal (wait_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    accept   = 1'b0;
    refuse   = 1'b0;
    ack_take = 1'b0;
    timeout  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          Stall = 1'b1;
          if (bad) begin
            refuse   = 1'b1;
            state_nx = ST_DONE;
          end else begin
            accept   = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        Stall = 1'b1;
        if (mem_ack) begin
          // An ack in the last allowed cycle still completes normally.
          ack_take = 1'b1;
          state_nx = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (wait_last) begin
            timeout  = 1'b1;
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The finished instruction is still on the inputs here; going
        // straight back to IDLE keeps it from being issued a second time.
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign mem_req = (state == ST_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      Memory_read_data <= 16'h0000;
      mem_addr         <= 16'h0000;
      mem_wdata        <= 16'h0000;
      mem_we           <= 1'b0;
      Err              <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= ALU_Out;
        mem_wdata <= MemWriteData;
        mem_we    <= MemWrite_cntrl;
      end
      if (ack_take && !mem_we) begin
        Memory_read_data <= mem_rdata;
      end else if (timeout) begin
        Memory_read_data <= ERR_RDATA;
      end
      if (refuse || timeout) begin
        Err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        MemRead_cntrl;
  logic        MemWrite_cntrl;
  logic [15:0] ALU_Out;
  logic [15:0] MemWriteData;
  logic [15:0] Memory_read_data;
  logic        Stall;
  logic        Err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .MemRead_cntrl    (MemRead_cntrl),
    .MemWrite_cntrl   (MemWrite_cntrl),
    .ALU_Out          (ALU_Out),
    .MemWriteData     (MemWriteData),
    .Memory_read_data (Memory_read_data),
    .Stall            (Stall),
    .Err              (Err),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = REQ cycle (1-based) in which memory acks; 0 = never acks.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          k;
    logic [15:0] rdata;
    int          e_stall;
    int          e_req;
    logic [15:0] e_rdd;
    logic        e_err;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    MemRead_cntrl = 1'b0;
    MemWrite_cntrl = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one instruction from an IDLE cycle until its DONE cycle and
  // returns what was observed. Memory acks outside REQ are randomised.
  task automatic run_txn(input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int k, input logic [15:0] rdata,
                         output int n_stall, output int n_req,
                         output logic [15:0] a_seen, output logic [15:0] w_seen,
                         output logic we_seen, output logic stable,
                         output logic [15:0] rdd_seen, output logic err_seen);
    logic done;
    MemRead_cntrl = rd;
    MemWrite_cntrl = wr;
    ALU_Out = addr;
    MemWriteData = wdata;
    n_stall = 0; n_req = 0; stable = 1'b1; done = 1'b0;
    a_seen = '0; w_seen = '0; we_seen = 1'b0; rdd_seen = '0; err_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        n_req++;
        if (n_req == 1) begin
          a_seen = mem_addr; w_seen = mem_wdata; we_seen = mem_we;
        end else if (mem_addr !== a_seen || mem_wdata !== w_seen || mem_we !== we_seen) begin
          stable = 1'b0;
        end
        mem_ack = (n_req == k);
        mem_rdata = (n_req == k) ? rdata : 16'($urandom);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      if (Stall) begin
        n_stall++;
      end else begin
        rdd_seen = Memory_read_data;
        err_seen = Err;
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_budget got=no_done exp=done_within_40");
    end
    @(posedge clk);
    #1;
    MemRead_cntrl = 1'b0;
    MemWrite_cntrl = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic apply_chk(input string nm, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int k, input logic [15:0] rdata,
                           input int e_stall, input int e_req,
                           input logic [15:0] e_rdd, input logic e_err);
    int ns, nr;
    logic [15:0] a, w, rdd;
    logic we, st, er;
    run_txn(rd, wr, addr, wdata, k, rdata, ns, nr, a, w, we, st, rdd, er);
    chk({nm, " stall_cycles"}, ns, e_stall);
    chk({nm, " req_cycles"}, nr, e_req);
    chk({nm, " read_data"}, rdd, e_rdd);
    chk({nm, " err"}, er, e_err);
    if (e_req > 0) begin
      chk({nm, " mem_addr"}, a, addr);
      chk({nm, " mem_wdata"}, w, wdata);
      chk({nm, " mem_we"}, we, wr);
      chk({nm, " req_stable"}, st, 1'b1);
    end
  endtask

  initial begin
    logic m_err;
    logic [15:0] m_rdd;
    logic [8:0] sp, rp;

    ALU_Out = '0; MemWriteData = '0; mem_rdata = '0;
    rst = 1'b1; MemRead_cntrl = 1'b0; MemWrite_cntrl = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst read_data", Memory_read_data, 16'h0000);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst mem_wdata", mem_wdata, 16'h0000);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst err", Err, 1'b0);
    chk("rst stall", Stall, 1'b0);
    @(posedge clk);
    #1;

    //            rd    wr    addr      wdata     k  rdata     stall req rdd       err
    tab[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'hBEEF, 3, 2, 16'hBEEF, 1'b0};
    tab[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'h5555, 2, 1, 16'hBEEF, 1'b0};
    tab[2] = '{1'b0, 1'b0, 16'h0022, 16'h9999, 1, 16'h4444, 0, 0, 16'hBEEF, 1'b0};
    tab[3] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'h1111, 1, 0, 16'hBEEF, 1'b1};
    tab[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 3, 16'hCAFE, 4, 3, 16'hCAFE, 1'b1};
    tab[5] = '{1'b1, 1'b1, 16'h0020, 16'h0101, 1, 16'h2222, 1, 0, 16'hCAFE, 1'b1};
    tab[6] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 0, 16'h3333, 5, 4, 16'h0000, 1'b1};
    tab[7] = '{1'b0, 1'b1, 16'h0202, 16'h7777, 4, 16'h6666, 5, 4, 16'h0000, 1'b1};

    for (int i = 0; i < 8; i++) begin
      apply_chk($sformatf("vec%0d", i), tab[i].rd, tab[i].wr, tab[i].addr,
                tab[i].wdata, tab[i].k, tab[i].rdata, tab[i].e_stall,
                tab[i].e_req, tab[i].e_rdd, tab[i].e_err);
    end

    // Randomised transactions against a transaction-level model.
    do_reset();
    m_err = 1'b0;
    m_rdd = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      logic rd, wr, acc, isbad, acked;
      logic [15:0] addr, wdata, rdata;
      int k, es, er;
      int kind;
      kind = $urandom_range(0, 9);
      rd = (kind <= 4) || (kind == 9);
      wr = (kind >= 5 && kind <= 7) || (kind == 9);
      addr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
      wdata = 16'($urandom);
      rdata = 16'($urandom);
      k = $urandom_range(0, 6);
      acc = rd | wr;
      isbad = acc && (addr[0] || (rd && wr));
      acked = (k >= 1) && (k <= TO);
      if (!acc) begin
        es = 0; er = 0;
      end else if (isbad) begin
        es = 1; er = 0; m_err = 1'b1;
      end else if (acked) begin
        es = 1 + k; er = k;
        if (rd) m_rdd = rdata;
      end else begin
        es = 1 + TO; er = TO; m_err = 1'b1; m_rdd = 16'h0000;
      end
      apply_chk($sformatf("rnd%0d", i), rd, wr, addr, wdata, k, rdata, es, er, m_rdd, m_err);
    end

    // Reset in the second REQ cycle, with prior state made non-zero.
    do_reset();
    apply_chk("pre_bad", 1'b1, 1'b0, 16'h0005, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 1'b1);
    apply_chk("pre_ld", 1'b1, 1'b0, 16'h0090, 16'h4321, 1, 16'h1357, 2, 1, 16'h1357, 1'b1);
    MemRead_cntrl = 1'b1; ALU_Out = 16'h0044; MemWriteData = 16'hABCD; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstreq in_req2", mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; MemRead_cntrl = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    chk("rstreq mem_req", mem_req, 1'b0);
    chk("rstreq stall", Stall, 1'b0);
    chk("rstreq read_data", Memory_read_data, 16'h0000);
    chk("rstreq err", Err, 1'b0);
    chk("rstreq mem_addr", mem_addr, 16'h0000);
    chk("rstreq mem_wdata", mem_wdata, 16'h0000);
    chk("rstreq mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack read_data", Memory_read_data, 16'h0000);
    chk("late_ack mem_req", mem_req, 1'b0);
    @(posedge clk); #1;

    // Back-to-back loads with a load held on the inputs throughout.
    MemRead_cntrl = 1'b1; ALU_Out = 16'h0080;
    sp = '0; rp = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      sp = {sp[7:0], Stall};
      rp = {rp[7:0], mem_req};
      mem_ack = mem_req;
      mem_rdata = 16'h0A0A;
    end
    MemRead_cntrl = 1'b0;
    mem_ack = 1'b0;
    chk("b2b stall_pattern", sp, 9'b110110110);
    chk("b2b req_pattern", rp, 9'b010010010);
    chk("b2b read_data", Memory_read_data, 16'h0A0A);
    chk("b2b err", Err, 1'b0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
